// File: rtl/enemy_hit_manager.sv
// Checks every bullet against every enemy hitbox, tracks health and runs each slot's spawn/alive/boom/dead lifecycle.
// Latency: inputs registered at edge k, results at edge k+1 (2-clock bullet-to-consume); no backpressure, pulses are fire-and-forget.
module enemy_hit_manager #(
   parameter int N_ENEMY     = 4,
   parameter int N_BULLET    = 4,
   parameter int COORD_W     = 10,
   parameter int HEALTH_W    = 3,
   parameter int INIT_HEALTH = 3,
   parameter int X_LO        = 10,
   parameter int X_HI        = 50,
   parameter int Y_LO        = 50,
   parameter int Y_HI        = 40,
   parameter int Y_OFFSET    = 480,
   parameter int BOOM_FRAMES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_tick,
   input  logic [N_ENEMY*COORD_W-1:0]     ep_x,
   input  logic [N_ENEMY*COORD_W-1:0]     ep_y,
   input  logic [N_ENEMY-1:0]             enemy_en,
   input  logic [N_ENEMY-1:0]             enemy_spawn,
   input  logic [N_BULLET*COORD_W-1:0]    b_x,
   input  logic [N_BULLET*COORD_W-1:0]    b_y,
   input  logic [N_BULLET-1:0]            b_en,
   output logic [N_BULLET-1:0]            b_consume,
   output logic [N_ENEMY*HEALTH_W-1:0]    enemy_health,
   output logic [N_ENEMY-1:0]             enemy_alive,
   output logic [N_ENEMY-1:0]             boom,
   output logic [N_ENEMY-1:0]             kill_pulse
);

   localparam int SW    = COORD_W + 2;
   localparam int CNT_W = $clog2(BOOM_FRAMES + 1);
   localparam int DMG_W = $clog2(N_BULLET + 1);

   localparam logic signed [SW-1:0] XLO_S = SW'(X_LO);
   localparam logic signed [SW-1:0] XHI_S = SW'(X_HI);
   localparam logic signed [SW-1:0] YLO_S = SW'(Y_LO);
   localparam logic signed [SW-1:0] YHI_S = SW'(Y_HI);
   localparam logic signed [SW-1:0] YOF_S = SW'(Y_OFFSET);

   typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_BOOM, S_DEAD} slot_st_t;

   logic [N_ENEMY*COORD_W-1:0]  ep_x_r, ep_y_r;
   logic [N_ENEMY-1:0]          enemy_en_r;
   logic [N_BULLET*COORD_W-1:0] b_x_r, b_y_r;
   logic [N_BULLET-1:0]         b_en_r;
   logic [N_BULLET-1:0]         lock;
   logic [N_BULLET-1:0]         consume_nxt;
   logic [N_ENEMY-1:0]          kill_nxt;

   slot_st_t              st     [N_ENEMY];
   slot_st_t              st_nxt [N_ENEMY];
   logic [HEALTH_W-1:0]   hp     [N_ENEMY];
   logic [HEALTH_W-1:0]   hp_nxt [N_ENEMY];
   logic [CNT_W-1:0]      cnt    [N_ENEMY];
   logic [CNT_W-1:0]      cnt_nxt[N_ENEMY];
   logic [DMG_W-1:0]      dmg    [N_ENEMY];

   // Coordinates are zero-extended into a wider signed space so hitbox edges can go negative without wrapping.
   always_comb begin
      logic signed [SW-1:0] bx, by, ex, ey;
      logic                 found;
      bx          = '0;
      by          = '0;
      ex          = '0;
      ey          = '0;
      found       = 1'b0;
      consume_nxt = '0;
      for (int j = 0; j < N_ENEMY; j++) dmg[j] = '0;
      for (int i = 0; i < N_BULLET; i++) begin
         bx    = signed'(SW'(b_x_r[i*COORD_W +: COORD_W]));
         by    = signed'(SW'(b_y_r[i*COORD_W +: COORD_W]));
         found = 1'b0;
         for (int j = 0; j < N_ENEMY; j++) begin
            ex = signed'(SW'(ep_x_r[j*COORD_W +: COORD_W]));
            ey = signed'(SW'(ep_y_r[j*COORD_W +: COORD_W])) + YOF_S;
            if (!found && b_en_r[i] && !lock[i] && enemy_en_r[j] && st[j] == S_ALIVE &&
                bx >= ex - XLO_S && bx < ex + XHI_S && by > ey - YLO_S && by < ey + YHI_S) begin
               found  = 1'b1;
               dmg[j] = dmg[j] + DMG_W'(1);
            end
         end
         consume_nxt[i] = found;
      end
   end

   always_comb begin
      kill_nxt = '0;
      for (int j = 0; j < N_ENEMY; j++) begin
         st_nxt[j]  = st[j];
         hp_nxt[j]  = hp[j];
         cnt_nxt[j] = cnt[j];
         case (st[j])
            S_IDLE, S_DEAD: begin
               if (enemy_spawn[j]) begin
                  st_nxt[j] = S_ALIVE;
                  hp_nxt[j] = HEALTH_W'(INIT_HEALTH);
               end
            end
            S_ALIVE: begin
               if (int'(dmg[j]) >= int'(hp[j])) begin
                  st_nxt[j]   = S_BOOM;
                  hp_nxt[j]   = '0;
                  cnt_nxt[j]  = '0;
                  kill_nxt[j] = 1'b1;
               end else begin
                  hp_nxt[j] = hp[j] - HEALTH_W'(dmg[j]);
               end
            end
            S_BOOM: begin
               if (frame_tick) begin
                  if (cnt[j] == CNT_W'(BOOM_FRAMES - 1)) st_nxt[j] = S_DEAD;
                  else                                   cnt_nxt[j] = cnt[j] + CNT_W'(1);
               end
            end
            default: st_nxt[j] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ep_x_r      <= '0;
         ep_y_r      <= '0;
         enemy_en_r  <= '0;
         b_x_r       <= '0;
         b_y_r       <= '0;
         b_en_r      <= '0;
         lock        <= '0;
         b_consume   <= '0;
         kill_pulse  <= '0;
         enemy_alive <= '0;
         boom        <= '0;
         for (int j = 0; j < N_ENEMY; j++) begin
            st[j]  <= S_IDLE;
            hp[j]  <= '0;
            cnt[j] <= '0;
         end
      end else begin
         ep_x_r     <= ep_x;
         ep_y_r     <= ep_y;
         enemy_en_r <= enemy_en;
         b_x_r      <= b_x;
         b_y_r      <= b_y;
         b_en_r     <= b_en;
         // Lock at the same edge as the consume pulse so a held bullet cannot score again.
         lock       <= b_en_r & (lock | consume_nxt);
         b_consume  <= consume_nxt;
         kill_pulse <= kill_nxt;
         for (int j = 0; j < N_ENEMY; j++) begin
            st[j]          <= st_nxt[j];
            hp[j]          <= hp_nxt[j];
            cnt[j]         <= cnt_nxt[j];
            enemy_alive[j] <= (st_nxt[j] == S_ALIVE);
            boom[j]        <= (st_nxt[j] == S_BOOM);
         end
      end
   end

   always_comb begin
      enemy_health = '0;
      for (int j = 0; j < N_ENEMY; j++) enemy_health[j*HEALTH_W +: HEALTH_W] = hp[j];
   end

endmodule

// File: tb/tb_enemy_hit_manager.sv
// Bench for enemy_hit_manager: directed scenarios with fixed expectations plus random traffic against a reference model.
module tb_enemy_hit_manager;
   localparam int NE = 4;
   localparam int NB = 4;
   localparam int CW = 10;
   localparam int HW = 3;
   localparam int M_IDLE = 0, M_ALIVE = 1, M_BOOM = 2, M_DEAD = 3;

   logic clk = 1'b0;
   logic rst;
   logic frame_tick;
   logic [NE-1:0] enemy_en, enemy_spawn;
   logic [NB-1:0] b_en;
   logic [NE*CW-1:0] ep_x, ep_y;
   logic [NB*CW-1:0] b_x, b_y;
   logic [NB-1:0] b_consume;
   logic [NE*HW-1:0] enemy_health;
   logic [NE-1:0] enemy_alive, boom, kill_pulse;

   int ex_a[NE], ey_a[NE], bx_a[NB], by_a[NB];
   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_st[NE], m_hp[NE], m_left[NE];
   bit m_lock[NB];
   bit [NB-1:0] m_cons;
   bit [NE-1:0] m_kill;
   int r_ex[NE], r_ey[NE], r_bx[NB], r_by[NB];
   bit [NE-1:0] r_en;
   bit [NB-1:0] r_ben;

   always #5 clk = ~clk;

   always_comb begin
      ep_x = '0; ep_y = '0; b_x = '0; b_y = '0;
      for (int j = 0; j < NE; j++) begin
         ep_x[j*CW +: CW] = CW'(ex_a[j]);
         ep_y[j*CW +: CW] = CW'(ey_a[j]);
      end
      for (int i = 0; i < NB; i++) begin
         b_x[i*CW +: CW] = CW'(bx_a[i]);
         b_y[i*CW +: CW] = CW'(by_a[i]);
      end
   end

   enemy_hit_manager dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .ep_x(ep_x), .ep_y(ep_y), .enemy_en(enemy_en), .enemy_spawn(enemy_spawn),
      .b_x(b_x), .b_y(b_y), .b_en(b_en), .b_consume(b_consume),
      .enemy_health(enemy_health), .enemy_alive(enemy_alive), .boom(boom), .kill_pulse(kill_pulse)
   );

   task automatic model_reset();
      for (int j = 0; j < NE; j++) begin
         m_st[j] = M_IDLE; m_hp[j] = 0; m_left[j] = 0; r_ex[j] = 0; r_ey[j] = 0;
      end
      for (int i = 0; i < NB; i++) begin
         m_lock[i] = 0; r_bx[i] = 0; r_by[i] = 0;
      end
      m_cons = '0; m_kill = '0; r_en = '0; r_ben = '0;
   endtask

   // One clock of game rules: hits from last cycle's positions, then slot lifecycle.
   task automatic model_step();
      int dmg[NE];
      for (int j = 0; j < NE; j++) dmg[j] = 0;
      for (int i = 0; i < NB; i++) begin
         m_cons[i] = 0;
         if (r_ben[i] && !m_lock[i])
            for (int j = 0; j < NE; j++)
               if (!m_cons[i] && r_en[j] && m_st[j] == M_ALIVE &&
                   r_bx[i] >= r_ex[j] - 10 && r_bx[i] < r_ex[j] + 50 &&
                   r_by[i] > r_ey[j] + 480 - 50 && r_by[i] < r_ey[j] + 480 + 40) begin
                  m_cons[i] = 1;
                  dmg[j]++;
               end
      end
      for (int j = 0; j < NE; j++) begin
         m_kill[j] = 0;
         if (m_st[j] == M_IDLE || m_st[j] == M_DEAD) begin
            if (enemy_spawn[j]) begin m_st[j] = M_ALIVE; m_hp[j] = 3; end
         end else if (m_st[j] == M_ALIVE) begin
            m_hp[j] = (m_hp[j] > dmg[j]) ? m_hp[j] - dmg[j] : 0;
            if (m_hp[j] == 0) begin m_st[j] = M_BOOM; m_kill[j] = 1; m_left[j] = 16; end
         end else if (frame_tick) begin
            m_left[j]--;
            if (m_left[j] == 0) m_st[j] = M_DEAD;
         end
      end
      for (int i = 0; i < NB; i++) m_lock[i] = r_ben[i] && (m_lock[i] || m_cons[i]);
      for (int j = 0; j < NE; j++) begin r_ex[j] = ex_a[j]; r_ey[j] = ey_a[j]; end
      for (int i = 0; i < NB; i++) begin r_bx[i] = bx_a[i]; r_by[i] = by_a[i]; end
      r_en = enemy_en; r_ben = b_en;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
   endtask

   task automatic clear_inputs();
      for (int j = 0; j < NE; j++) begin ex_a[j] = 0; ey_a[j] = 0; end
      for (int i = 0; i < NB; i++) begin bx_a[i] = 0; by_a[i] = 0; end
      enemy_en = '0; enemy_spawn = '0; b_en = '0; frame_tick = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic do_spawn(input int j, input int x, input int y);
      ex_a[j] = x; ey_a[j] = y; enemy_en[j] = 1'b1; enemy_spawn[j] = 1'b1;
      tick();
      enemy_spawn[j] = 1'b0;
   endtask

   task automatic shoot(input int i, input int x, input int y);
      bx_a[i] = x; by_a[i] = y; b_en[i] = 1'b1;
      tick(); tick();
   endtask

   task automatic release_bullet(input int i);
      b_en[i] = 1'b0;
      tick(); tick();
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick(); tick();
      vectors++;
      if ({b_consume, enemy_health, enemy_alive, boom, kill_pulse} !== '0) begin
         miscompares++; $display("FAIL reset_outputs act=%h exp=0", {b_consume, enemy_health, enemy_alive, boom, kill_pulse});
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({b_consume, enemy_health, enemy_alive, boom, kill_pulse} !== '0) begin
         miscompares++; $display("FAIL post_reset_idle act=%h exp=0", {b_consume, enemy_health, enemy_alive, boom, kill_pulse});
      end
   endtask

   task automatic test_single_hit();
      apply_reset();
      do_spawn(0, 100, 0);
      vectors++;
      if (enemy_alive[0] !== 1'b1 || enemy_health[2:0] !== 3'd3) begin
         miscompares++; $display("FAIL spawn alive=%b health=%0d exp alive=1 health=3", enemy_alive[0], enemy_health[2:0]);
      end
      bx_a[0] = 120; by_a[0] = 470; b_en[0] = 1'b1;
      tick();
      vectors++;
      if (b_consume !== 4'b0000) begin miscompares++; $display("FAIL consume_early act=%b exp=0000", b_consume); end
      tick();
      vectors++;
      if (b_consume !== 4'b0001 || enemy_health[2:0] !== 3'd2) begin
         miscompares++; $display("FAIL first_hit consume=%b health=%0d exp 0001/2", b_consume, enemy_health[2:0]);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors++;
         if (b_consume !== 4'b0000 || enemy_health[2:0] !== 3'd2) begin
            miscompares++; $display("FAIL locked_hold%0d consume=%b health=%0d exp 0000/2", k, b_consume, enemy_health[2:0]);
         end
      end
   endtask

   task automatic test_kill_boom();
      int kills;
      release_bullet(0);
      shoot(0, 120, 470);
      vectors++;
      if (b_consume !== 4'b0001 || enemy_health[2:0] !== 3'd1) begin
         miscompares++; $display("FAIL second_hit consume=%b health=%0d exp 0001/1", b_consume, enemy_health[2:0]);
      end
      release_bullet(0);
      shoot(0, 120, 470);
      vectors++;
      if (kill_pulse !== 4'b0001 || boom !== 4'b0001 || enemy_alive !== 4'b0000 || enemy_health !== '0) begin
         miscompares++; $display("FAIL kill kill=%b boom=%b alive=%b health=%h exp 0001/0001/0000/0", kill_pulse, boom, enemy_alive, enemy_health);
      end
      kills = 0;
      b_en[0] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         frame_tick = 1'b1; tick(); kills += int'(kill_pulse[0]);
         frame_tick = 1'b0; tick(); kills += int'(kill_pulse[0]);
         vectors++;
         if (boom[0] !== (k < 16)) begin
            miscompares++; $display("FAIL boom_frame%0d act=%b exp=%b", k, boom[0], (k < 16));
         end
      end
      vectors++;
      if (kills != 0 || enemy_alive[0] !== 1'b0) begin
         miscompares++; $display("FAIL after_boom extra_kills=%0d alive=%b exp 0/0", kills, enemy_alive[0]);
      end
   endtask

   task automatic test_edges();
      int px[5] = '{90, 150, 100, 100, 100};
      int py[5] = '{480, 480, 430, 431, 520};
      bit pe[5] = '{1, 0, 0, 1, 0};
      apply_reset();
      do_spawn(0, 100, 0);
      for (int p = 0; p < 5; p++) begin
         shoot(0, px[p], py[p]);
         vectors++;
         if (b_consume[0] !== pe[p]) begin
            miscompares++; $display("FAIL edge(%0d,%0d) consume=%b exp=%b", px[p], py[p], b_consume[0], pe[p]);
         end
         release_bullet(0);
      end
      vectors++;
      if (enemy_health[2:0] !== 3'd1) begin miscompares++; $display("FAIL edge_health act=%0d exp=1", enemy_health[2:0]); end
   endtask

   task automatic test_arbitration();
      apply_reset();
      do_spawn(0, 100, 0); do_spawn(1, 110, 0); do_spawn(2, 400, 0);
      shoot(0, 120, 480);
      vectors++;
      if (b_consume !== 4'b0001 || enemy_health[2:0] !== 3'd2 || enemy_health[5:3] !== 3'd3) begin
         miscompares++; $display("FAIL overlap consume=%b h0=%0d h1=%0d exp 0001/2/3", b_consume, enemy_health[2:0], enemy_health[5:3]);
      end
      release_bullet(0);
      for (int k = 0; k < 2; k++) begin shoot(1, 410, 480); release_bullet(1); end
      vectors++;
      if (enemy_health[8:6] !== 3'd1) begin miscompares++; $display("FAIL slot2_prep act=%0d exp=1", enemy_health[8:6]); end
      bx_a[1] = 410; by_a[1] = 480; bx_a[2] = 420; by_a[2] = 490;
      b_en[1] = 1'b1; b_en[2] = 1'b1;
      tick(); tick();
      vectors++;
      if (b_consume !== 4'b0110 || enemy_health[8:6] !== 3'd0 || kill_pulse !== 4'b0100 || boom !== 4'b0100) begin
         miscompares++; $display("FAIL double_hit consume=%b h2=%0d kill=%b boom=%b exp 0110/0/0100/0100", b_consume, enemy_health[8:6], kill_pulse, boom);
      end
      b_en = '0; tick();
   endtask

   task automatic test_disable_dead();
      apply_reset();
      do_spawn(3, 200, 100);
      enemy_en[3] = 1'b0;
      shoot(0, 210, 580);
      vectors++;
      if (b_consume !== 4'b0000 || enemy_health[11:9] !== 3'd3) begin
         miscompares++; $display("FAIL disabled consume=%b h3=%0d exp 0000/3", b_consume, enemy_health[11:9]);
      end
      release_bullet(0);
      enemy_en[3] = 1'b1; ex_a[1] = 200; ey_a[1] = 100; enemy_en[1] = 1'b1;
      shoot(0, 210, 580);
      vectors++;
      if (b_consume !== 4'b0001 || enemy_health[11:9] !== 3'd2 || enemy_health[5:3] !== 3'd0) begin
         miscompares++; $display("FAIL idle_skip consume=%b h3=%0d h1=%0d exp 0001/2/0", b_consume, enemy_health[11:9], enemy_health[5:3]);
      end
      for (int k = 0; k < 2; k++) begin release_bullet(0); shoot(0, 210, 580); end
      release_bullet(0);
      enemy_spawn[3] = 1'b1; tick(); enemy_spawn[3] = 1'b0;
      vectors++;
      if (boom[3] !== 1'b1 || enemy_alive[3] !== 1'b0 || enemy_health[11:9] !== 3'd0) begin
         miscompares++; $display("FAIL spawn_in_boom boom=%b alive=%b h3=%0d exp 1/0/0", boom[3], enemy_alive[3], enemy_health[11:9]);
      end
      frames(16);
      shoot(0, 210, 580);
      vectors++;
      if (b_consume !== 4'b0000 || boom[3] !== 1'b0 || enemy_alive[3] !== 1'b0) begin
         miscompares++; $display("FAIL dead_slot consume=%b boom=%b alive=%b exp 0000/0/0", b_consume, boom[3], enemy_alive[3]);
      end
      release_bullet(0);
      enemy_spawn[3] = 1'b1; tick(); enemy_spawn[3] = 1'b0;
      vectors++;
      if (enemy_alive[3] !== 1'b1 || enemy_health[11:9] !== 3'd3) begin
         miscompares++; $display("FAIL respawn alive=%b h3=%0d exp 1/3", enemy_alive[3], enemy_health[11:9]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      do_spawn(0, 100, 0);
      for (int k = 0; k < 3; k++) begin shoot(0, 120, 480); release_bullet(0); end
      vectors++;
      if (boom[0] !== 1'b1) begin miscompares++; $display("FAIL rst_boom_prep act=%b exp=1", boom[0]); end
      rst = 1'b1; #1;
      vectors++;
      if ({b_consume, enemy_health, enemy_alive, boom, kill_pulse} !== '0) begin
         miscompares++; $display("FAIL rst_in_boom act=%h exp=0", {b_consume, enemy_health, enemy_alive, boom, kill_pulse});
      end
      tick(); rst = 1'b0;
      do_spawn(0, 100, 0);
      for (int k = 0; k < 2; k++) begin shoot(0, 120, 480); release_bullet(0); end
      bx_a[0] = 120; by_a[0] = 480; b_en[0] = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if ({b_consume, enemy_health, enemy_alive, boom, kill_pulse} !== '0) begin
         miscompares++; $display("FAIL rst_in_hit act=%h exp=0", {b_consume, enemy_health, enemy_alive, boom, kill_pulse});
      end
      rst = 1'b0;
      b_en = '0;
   endtask

   task automatic test_random();
      logic [NE*HW-1:0] e_h;
      logic [NE-1:0]    e_a, e_b;
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int j = 0; j < NE; j++) begin
            if ($urandom_range(0, 7) == 0) begin ex_a[j] = $urandom_range(0, 200); ey_a[j] = $urandom_range(0, 40); end
            enemy_en[j]    = ($urandom_range(0, 9) != 0);
            enemy_spawn[j] = ($urandom_range(0, 9) == 0);
         end
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, 5) == 0) begin
               b_en[i] = ~b_en[i]; bx_a[i] = $urandom_range(0, 260); by_a[i] = $urandom_range(420, 570);
            end
         frame_tick = 1'($urandom_range(0, 1));
         tick();
         e_h = '0;
         for (int j = 0; j < NE; j++) begin
            e_h[j*HW +: HW] = (m_st[j] == M_ALIVE) ? HW'(m_hp[j]) : '0;
            e_a[j] = (m_st[j] == M_ALIVE);
            e_b[j] = (m_st[j] == M_BOOM);
         end
         vectors++;
         if (b_consume !== m_cons) begin miscompares++; $display("FAIL rnd%0d consume act=%b exp=%b", c, b_consume, m_cons); end
         vectors++;
         if (kill_pulse !== m_kill) begin miscompares++; $display("FAIL rnd%0d kill act=%b exp=%b", c, kill_pulse, m_kill); end
         vectors++;
         if (enemy_health !== e_h) begin miscompares++; $display("FAIL rnd%0d health act=%h exp=%h", c, enemy_health, e_h); end
         vectors++;
         if (enemy_alive !== e_a) begin miscompares++; $display("FAIL rnd%0d alive act=%b exp=%b", c, enemy_alive, e_a); end
         vectors++;
         if (boom !== e_b) begin miscompares++; $display("FAIL rnd%0d boom act=%b exp=%b", c, boom, e_b); end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_kill_boom();
      test_edges();
      test_arbitration();
      test_disable_dead();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
